// File: rtl/bram_arbiter_if.sv
// bram_arbiter_if -- signal bundle between the block RAM arbiter, its two
// clients (ports A and B) and the single-port RAM instance.
//
// Parameters
//   n : address width (RAM depth is 2**n words)
//   w : data width
//
// Signals
//   x_req/x_we/x_addr/x_wdata : client request, held until x_gnt (x = a, b)
//   x_gnt                     : one-cycle pulse, request accepted
//   x_rvalid/x_rdata          : one-cycle read-return strobe and data
//   mem_addr/mem_rw/mem_din   : registered RAM address, write enable, data in
//   mem_dout                  : RAM registered read data
//   busy                      : requests are not being accepted
//   state_dbg                 : current arbiter state (0 = IDLE, 1 = INIT)
//
// Modports
//   slave  : the arbiter's view
//   master : the environment's view (clients plus RAM)

interface bram_arbiter_if #(
    parameter int n = 13,
    parameter int w = 16
) ();

    logic         a_req;
    logic         a_we;
    logic [n-1:0] a_addr;
    logic [w-1:0] a_wdata;
    logic         a_gnt;
    logic         a_rvalid;
    logic [w-1:0] a_rdata;

    logic         b_req;
    logic         b_we;
    logic [n-1:0] b_addr;
    logic [w-1:0] b_wdata;
    logic         b_gnt;
    logic         b_rvalid;
    logic [w-1:0] b_rdata;

    logic [n-1:0] mem_addr;
    logic         mem_rw;
    logic [w-1:0] mem_din;
    logic [w-1:0] mem_dout;

    logic         busy;
    logic         state_dbg;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output mem_addr, mem_rw, mem_din,
        input  mem_dout,
        output busy, state_dbg
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  mem_addr, mem_rw, mem_din,
        output mem_dout,
        input  busy, state_dbg
    );

endinterface

// File: rtl/bram_arbiter.sv
// bram_arbiter -- two-requester round-robin arbiter and sequencer for a
// shared single-port block RAM with 1-cycle registered read data.
//
// Ports
//   clk   : system clock, rising edge
//   clear : synchronous active-high reset
//   bus   : bram_arbiter_if.slave -- client A/B request/grant/read-return
//           signals, RAM address/write-enable/data, busy and state_dbg
//
// Handshake
//   A client raises x_req with x_we/x_addr/x_wdata and holds them until it
//   sees x_gnt. x_gnt is a one-cycle pulse in the cycle after the request
//   was accepted; during that pulse the client is not sampled and may
//   change or drop its request. For a read, x_rvalid pulses one cycle after
//   x_gnt and x_rdata carries the RAM output for that cycle only. Writes
//   return nothing.
//
// Optional feature (macro BRAM_ARB_ZERO_INIT_EN)
//   When defined, every clear starts an INIT sweep that writes zero to all
//   2**n addresses, one per cycle, with busy high; arbitration resumes in
//   IDLE afterwards. When undefined, busy is tied low, the block resets
//   straight to IDLE and RAM contents are left untouched.

module bram_arbiter #(
    parameter int n = 13,
    parameter int w = 16
) (
    input logic           clk,
    input logic           clear,
    bram_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        INIT = 1'b1
    } state_t;

    // Owner encoding used by the round-robin pointer and the read pipeline.
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t       state_q, state_d;

    logic         a_gnt_q, a_gnt_d;
    logic         b_gnt_q, b_gnt_d;

    logic [n-1:0] mem_addr_q, mem_addr_d;
    logic         mem_rw_q, mem_rw_d;
    logic [w-1:0] mem_din_q, mem_din_d;

    logic         last_winner_q, last_winner_d;

    // Read-return pipeline: stage 1 is the RAM capture cycle (grant cycle),
    // stage 2 is the cycle the RAM output is valid.
    logic         rd1_valid_q, rd1_valid_d;
    logic         rd1_owner_q, rd1_owner_d;
    logic         rd2_valid_q;
    logic         rd2_owner_q;

`ifdef BRAM_ARB_ZERO_INIT_EN
    logic [n-1:0] init_addr_q, init_addr_d;
`endif

    logic         a_elig;
    logic         b_elig;
    logic         win_a;
    logic         win_b;

    // ------------------------------------------------------------------
    // Next-state and issue logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        a_gnt_d       = 1'b0;
        b_gnt_d       = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_rw_d      = 1'b0;         // never leave a stale write enable up
        mem_din_d     = mem_din_q;
        last_winner_d = last_winner_q;
        rd1_valid_d   = 1'b0;
        rd1_owner_d   = rd1_owner_q;
`ifdef BRAM_ARB_ZERO_INIT_EN
        init_addr_d   = init_addr_q;
`endif

        // A requester is not re-sampled in its own grant cycle; this is what
        // makes a lone requester see a grant every second cycle.
        a_elig = bus.a_req && !a_gnt_q && (state_q == IDLE);
        b_elig = bus.b_req && !b_gnt_q && (state_q == IDLE);

        // On a tie the requester that did not win last time goes first.
        win_a  = a_elig && (!b_elig || (last_winner_q == PORT_B));
        win_b  = b_elig && !win_a;

        case (state_q)
            IDLE: begin
                if (win_a) begin
                    a_gnt_d       = 1'b1;
                    mem_addr_d    = bus.a_addr;
                    mem_rw_d      = bus.a_we;
                    mem_din_d     = bus.a_wdata;
                    last_winner_d = PORT_A;
                    rd1_valid_d   = !bus.a_we;
                    rd1_owner_d   = PORT_A;
                end else if (win_b) begin
                    b_gnt_d       = 1'b1;
                    mem_addr_d    = bus.b_addr;
                    mem_rw_d      = bus.b_we;
                    mem_din_d     = bus.b_wdata;
                    last_winner_d = PORT_B;
                    rd1_valid_d   = !bus.b_we;
                    rd1_owner_d   = PORT_B;
                end
            end

            INIT: begin
`ifdef BRAM_ARB_ZERO_INIT_EN
                // The sweep address is presented combinationally below, so
                // the last address is written in the cycle it is shown and
                // IDLE follows directly.
                init_addr_d = init_addr_q + n'(1);
                if (init_addr_q == {n{1'b1}}) begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear) begin
`ifdef BRAM_ARB_ZERO_INIT_EN
            state_q     <= INIT;
            init_addr_q <= '0;
`else
            state_q     <= IDLE;
`endif
            a_gnt_q       <= 1'b0;
            b_gnt_q       <= 1'b0;
            mem_addr_q    <= '0;
            mem_rw_q      <= 1'b0;
            mem_din_q     <= '0;
            last_winner_q <= PORT_B;  // A wins the first tie
            rd1_valid_q   <= 1'b0;
            rd1_owner_q   <= PORT_A;
            rd2_valid_q   <= 1'b0;
            rd2_owner_q   <= PORT_A;
        end else begin
            state_q       <= state_d;
`ifdef BRAM_ARB_ZERO_INIT_EN
            init_addr_q   <= init_addr_d;
`endif
            a_gnt_q       <= a_gnt_d;
            b_gnt_q       <= b_gnt_d;
            mem_addr_q    <= mem_addr_d;
            mem_rw_q      <= mem_rw_d;
            mem_din_q     <= mem_din_d;
            last_winner_q <= last_winner_d;
            rd1_valid_q   <= rd1_valid_d;
            rd1_owner_q   <= rd1_owner_d;
            rd2_valid_q   <= rd1_valid_q;
            rd2_owner_q   <= rd1_owner_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.a_gnt     = a_gnt_q;
    assign bus.b_gnt     = b_gnt_q;

    assign bus.a_rvalid  = rd2_valid_q && (rd2_owner_q == PORT_A);
    assign bus.b_rvalid  = rd2_valid_q && (rd2_owner_q == PORT_B);

    // Read data is routed straight from the RAM; only meaningful with rvalid.
    assign bus.a_rdata   = bus.mem_dout;
    assign bus.b_rdata   = bus.mem_dout;

    assign bus.state_dbg = state_q;

`ifdef BRAM_ARB_ZERO_INIT_EN
    // During the sweep the RAM sees the sweep counter directly so that the
    // first address is written in the first cycle after clear.
    assign bus.mem_addr  = (state_q == INIT) ? init_addr_q : mem_addr_q;
    assign bus.mem_rw    = (state_q == INIT) ? 1'b1 : mem_rw_q;
    assign bus.mem_din   = (state_q == INIT) ? '0 : mem_din_q;
    assign bus.busy      = (state_q == INIT);
`else
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_rw    = mem_rw_q;
    assign bus.mem_din   = mem_din_q;
    assign bus.busy      = 1'b0;
`endif

endmodule

// File: tb/tb_bram_arbiter.sv
`timescale 1ns/1ps

module tb_bram_arbiter;

`ifdef BRAM_ARB_ZERO_INIT_EN
  localparam int N  = 4;
  localparam bit ZI = 1'b1;
`else
  localparam int N  = 13;
  localparam bit ZI = 1'b0;
`endif
  localparam int W     = 16;
  localparam int DEPTH = 1 << N;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  bram_arbiter_if #(.n(N), .w(W)) bus ();

  bram_arbiter #(.n(N), .w(W)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  // ---------------- RAM model ----------------
  logic [W-1:0] ram     [DEPTH];
  logic [W-1:0] ref_mem [DEPTH];

  always @(posedge clk) begin
    if (bus.mem_rw) ram[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= ram[bus.mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int gnt_cnt_a = 0, gnt_cnt_b = 0, rv_cnt_a = 0, rv_cnt_b = 0;

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  int           cyc_a_q[$];
  int           cyc_b_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.a_gnt) gnt_cnt_a++;
    if (bus.b_gnt) gnt_cnt_b++;
    if (bus.a_rvalid) begin
      rv_cnt_a++;
      if (exp_a_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_rvalid_unexpected: got rvalid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        check("a_rdata", 32'(bus.a_rdata), 32'(exp_a_q.pop_front()));
        check("a_rvalid_cycle", 32'(cyc), 32'(cyc_a_q.pop_front()));
      end
    end
    if (bus.b_rvalid) begin
      rv_cnt_b++;
      if (exp_b_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_rvalid_unexpected: got rvalid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        check("b_rdata", 32'(bus.b_rdata), 32'(exp_b_q.pop_front()));
        check("b_rvalid_cycle", 32'(cyc), 32'(cyc_b_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [N-1:0] addr, input logic [W-1:0] wdata);
    if (port == 1'b0) begin
      bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
    end else begin
      bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
    end
  endtask

  task automatic push_read(input bit port, input logic [W-1:0] d);
    if (port == 1'b0) begin exp_a_q.push_back(d); cyc_a_q.push_back(cyc + 1); end
    else              begin exp_b_q.push_back(d); cyc_b_q.push_back(cyc + 1); end
  endtask

  // Called at a negedge; raises the request and waits (bounded) for the grant.
  task automatic issue(input bit port, input bit we, input logic [N-1:0] addr,
                       input logic [W-1:0] wdata, input int exp_lat,
                       input bit use_exp, input logic [W-1:0] exp_data);
    int lat = -1;
    drive(port, 1'b1, we, addr, wdata);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if ((port == 1'b0 && bus.a_gnt) || (port == 1'b1 && bus.b_gnt)) begin
        lat = k;
        break;
      end
    end
    check(port ? "b_gnt_latency" : "a_gnt_latency", 32'(lat), 32'(exp_lat));
    drive(port, 1'b0, 1'b0, '0, '0);
    if (lat > 0) begin
      if (we) ref_mem[addr] = wdata;
      else    push_read(port, use_exp ? exp_data : ref_mem[addr]);
    end
  endtask

  task automatic wait_ready();
`ifdef BRAM_ARB_ZERO_INIT_EN
    for (int k = 0; k < DEPTH + 8; k++) begin
      if (!bus.busy) break;
      @(negedge clk);
    end
    check("init_done_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
  endtask

  task automatic do_reset();
    clear = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    wait_ready();
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    bit          port;
    bit          we;
    logic [12:0] addr;
    logic [15:0] wdata;
    bit          use_exp;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] ra, wa, wb;
    int ga0, gb0;

    vecs[0] = '{1'b0, 1'b1, 13'h0005, 16'hBEEF, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 13'h0005, 16'h0000, 1'b1, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b1, 13'h0100, 16'h00AA, 1'b0, 16'h0000};
    vecs[3] = '{1'b0, 1'b0, 13'h0100, 16'h0000, 1'b1, 16'h00AA};
    vecs[4] = '{1'b1, 1'b0, 13'h0005, 16'h0000, 1'b1, 16'hBEEF};
    vecs[5] = '{1'b0, 1'b1, 13'h0033, 16'h1234, 1'b0, 16'h0000};
    vecs[6] = '{1'b1, 1'b0, 13'h0033, 16'h0000, 1'b1, 16'h1234};
    vecs[7] = '{1'b1, 1'b1, 13'h1FFF, 16'hFFFF, 1'b0, 16'h0000};
    vecs[8] = '{1'b0, 1'b0, 13'h1FFF, 16'h0000, 1'b1, 16'hFFFF};
    vecs[9] = '{1'b0, 1'b0, 13'h0000, 16'h0000, 1'b0, 16'h0000};

    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = W'(i * 7 + 3);
      ref_mem[i] = W'(i * 7 + 3);
    end
    ra = N'(13'h0010); ram[ra] = 16'h1111; ref_mem[ra] = 16'h1111;
    ra = N'(13'h0020); ram[ra] = 16'h2222; ref_mem[ra] = 16'h2222;

    clear = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_a_gnt", 32'(bus.a_gnt), 32'd0);
    check("rst_b_gnt", 32'(bus.b_gnt), 32'd0);
    check("rst_a_rvalid", 32'(bus.a_rvalid), 32'd0);
    check("rst_b_rvalid", 32'(bus.b_rvalid), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_din", 32'(bus.mem_din), 32'd0);
    check("rst_mem_rw", 32'(bus.mem_rw), 32'(ZI));
    check("rst_busy", 32'(bus.busy), 32'(ZI));
    check("rst_state", 32'(bus.state_dbg), 32'(ZI));
    clear = 1'b0;
    wait_ready();

    // Table: single transactions, one idle cycle between them
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].port, vecs[i].we, N'(vecs[i].addr), vecs[i].wdata, 1,
            vecs[i].use_exp, vecs[i].exp_rdata);
      @(negedge clk);
      if (i == 1) begin
        @(negedge clk);
        check("t1_b_gnt_count", 32'(gnt_cnt_b), 32'd0);
        check("t1_b_rvalid_count", 32'(rv_cnt_b), 32'd0);
        check("t1_a_rvalid_count", 32'(rv_cnt_a), 32'd1);
      end
    end
    repeat (2) @(negedge clk);

    // Simultaneous requests right after reset: A first, B next cycle
    do_reset();
    fork
      issue(1'b0, 1'b0, N'(13'h0010), 16'h0000, 1, 1'b0, 16'h0000);
      issue(1'b1, 1'b0, N'(13'h0020), 16'h0000, 2, 1'b0, 16'h0000);
    join
    repeat (3) @(negedge clk);

    // Both held for 8 cycles, all writes: strict alternation
    do_reset();
    wa = N'(13'h0200);
    wb = N'(13'h0300);
    ga0 = gnt_cnt_a;
    gb0 = gnt_cnt_b;
    drive(1'b0, 1'b1, 1'b1, wa, 16'hA5A5);
    drive(1'b1, 1'b1, 1'b1, wb, 16'h5A5A);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("alt_a_gnt", 32'(bus.a_gnt), 32'(k % 2 == 0));
      check("alt_b_gnt", 32'(bus.b_gnt), 32'(k % 2 == 1));
      check("alt_mem_rw", 32'(bus.mem_rw), 32'd1);
      check("alt_mem_addr", 32'(bus.mem_addr), (k % 2 == 0) ? 32'(wa) : 32'(wb));
      if (k % 2 == 0) ref_mem[wa] = 16'hA5A5;
      else            ref_mem[wb] = 16'h5A5A;
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("alt_idle_mem_rw", 32'(bus.mem_rw), 32'd0);
    check("alt_a_total", 32'(gnt_cnt_a - ga0), 32'd4);
    check("alt_b_total", 32'(gnt_cnt_b - gb0), 32'd4);
    @(negedge clk);

    // A alone held high: granted every second cycle
    ra = N'(13'h0200);
    drive(1'b0, 1'b1, 1'b0, ra, 16'h0000);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("solo_a_gnt", 32'(bus.a_gnt), 32'(k % 2 == 0));
      check("solo_mem_rw", 32'(bus.mem_rw), 32'd0);
      if (k % 2 == 0) push_read(1'b0, ref_mem[ra]);
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);

    // clear in the cycle after a read grant drops the read
    drive(1'b0, 1'b1, 1'b0, N'(13'h0005), 16'h0000);
    @(negedge clk);
    check("clr_a_gnt", 32'(bus.a_gnt), 32'd1);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    clear = 1'b1;
    @(negedge clk);
    check("clr_a_rvalid", 32'(bus.a_rvalid), 32'd0);
    check("clr_a_gnt_low", 32'(bus.a_gnt), 32'd0);
    check("clr_mem_rw", 32'(bus.mem_rw), 32'(ZI));
    check("clr_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("clr_mem_din", 32'(bus.mem_din), 32'd0);
    check("clr_busy", 32'(bus.busy), 32'(ZI));
    clear = 1'b0;
    @(negedge clk);
    check("clr_a_rvalid_late", 32'(bus.a_rvalid), 32'd0);
    wait_ready();
    issue(1'b0, 1'b0, N'(13'h0033), 16'h0000, 1, 1'b0, 16'h0000);
    repeat (3) @(negedge clk);

`ifdef BRAM_ARB_ZERO_INIT_EN
    // Zero-init sweep with a request held throughout
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ra = N'(13'h0003);
    drive(1'b0, 1'b1, 1'b0, ra, 16'h0000);
    for (int k = 0; k < DEPTH; k++) begin
      check("init_busy", 32'(bus.busy), 32'd1);
      check("init_mem_addr", 32'(bus.mem_addr), 32'(k));
      check("init_mem_rw", 32'(bus.mem_rw), 32'd1);
      check("init_mem_din", 32'(bus.mem_din), 32'd0);
      check("init_a_gnt", 32'(bus.a_gnt), 32'd0);
      @(negedge clk);
    end
    check("init_end_busy", 32'(bus.busy), 32'd0);
    check("init_end_a_gnt", 32'(bus.a_gnt), 32'd0);
    @(negedge clk);
    check("init_post_a_gnt", 32'(bus.a_gnt), 32'd1);
    if (bus.a_gnt) push_read(1'b0, ref_mem[ra]);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
`endif

    check("a_queue_drained", 32'(exp_a_q.size()), 32'd0);
    check("b_queue_drained", 32'(exp_b_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared single-port block RAM (n-bit address, w-bit data, write-enable `read_write`, registered read data with 1-cycle latency).
- Accepts one access per cycle, drives registered memory-side signals, and returns read data with a valid strobe to the winning requester.
- Sits between the RAM instance and two client blocks (ports A and B).

Parameters:
n, 13, address width; memory depth is 2**n words
w, 16, data width

Ports:
clk  input  1  system clock, rising edge
clear  input  1  synchronous active-high reset
a_req  input  1  port A request; held with a_we/a_addr/a_wdata until a_gnt
a_we  input  1  port A access type: 1 = write, 0 = read
a_addr  input  n  port A address
a_wdata  input  w  port A write data
a_gnt  output  1  one-cycle pulse: port A request accepted
a_rvalid  output  1  one-cycle pulse: a_rdata valid (reads only)
a_rdata  output  w  port A read data
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as port A, for port B
mem_addr  output  n  to RAM addr
mem_rw  output  1  to RAM read_write
mem_din  output  w  to RAM data_in
mem_dout  input  w  from RAM data_out
busy  output  1  high while requests cannot be accepted (init sweep only)

Behaviour:
- Reset values (clear=1 at a rising edge): a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, mem_addr=0, mem_rw=0, mem_din=0, busy=0 (1 if the optional feature is enabled). Round-robin pointer last_winner=B, so A wins the first tie.
- Eligibility in cycle t: X is eligible if x_req=1, x_gnt=0 in cycle t, and the block is in IDLE. A requester is not re-sampled in its own grant cycle, so it may change req/addr/data while gnt is high.
- Arbitration:
  - One eligible requester: it wins.
  - Both eligible: the requester other than last_winner wins.
  - None eligible: no access.
- Issue, at the edge ending cycle t:
  - x_gnt<=1.
  - mem_addr<=x_addr, mem_rw<=x_we, mem_din<=x_wdata.
  - last_winner<=X.
- Non-issue cycles: mem_rw<=0 (the RAM must never see a stale write); mem_addr and mem_din hold their last values.
- Latency:
  - Request at cycle t → gnt in t+1 → RAM captures at the end of t+1.
  - For a read, x_rvalid=1 in cycle t+2, with x_rdata=mem_dout.
  - x_rdata is combinationally routed from mem_dout and is only meaningful while x_rvalid=1.
  - Writes produce no rvalid.
- Read-return tracking: two-stage pipeline of {valid, owner}; stage 1 is set on a read grant, stage 2 drives rvalid.
- Throughput:
  - Both requesters held high: grants alternate A,B,A,B…, one access per cycle.
  - Single requester held high: granted every second cycle.
- Read-after-write to the same address, from either port: the RAM returns new data provided the read is issued at least one cycle after the write.
- clear mid-operation: in-flight reads are dropped (no rvalid), pending requests are ignored, and the block re-enters its post-reset state.
- FSM states: IDLE (arbitrating); INIT (optional feature only).

Optional Feature:
- Macro: BRAM_ARB_ZERO_INIT_EN.
- Defined:
  - After clear, the FSM enters INIT with busy=1 and no grants.
  - Each cycle it drives mem_rw=1, mem_din=0, mem_addr=0,1,…,2**n-1, one address per cycle.
  - The cycle after address 2**n-1 is written, it enters IDLE and busy=0.
  - Requests raised during INIT are held by the requester and arbitrated normally once IDLE is reached.
  - clear during INIT restarts the sweep at 0.
- Undefined: no INIT state; busy is tied 0; the FSM resets directly to IDLE; RAM contents are left as preloaded.

Test Plan:
1. A writes 0xBEEF to addr 0x0005, then A reads 0x0005 → a_gnt one cycle after each request; a_rvalid two cycles after the read request with a_rdata=0xBEEF; b_gnt and b_rvalid stay 0.
2. a_req and b_req raised together after reset (A reads 0x0010, B reads 0x0020, preloaded 0x1111/0x2222) → a_gnt first, b_gnt the next cycle; a_rvalid with 0x1111, then b_rvalid with 0x2222 one cycle later.
3. Both requests held high for 8 cycles, all writes → grants alternate A,B,A,B…, 8 grants total; mem_rw=1 exactly in the grant cycles.
4. B writes 0x00AA to 0x0100, then A reads 0x0100 → a_rdata=0x00AA; separately, A alone held high → a_gnt every second cycle.
5. A read granted, clear asserted in the following cycle → no a_rvalid, mem_rw=0, all outputs at reset values; the next request is serviced normally.
6. With BRAM_ARB_ZERO_INIT_EN and n=4 → busy high 16 cycles; mem_addr steps 0..15 with mem_rw=1 and mem_din=0; a_req held during the sweep is granted only after busy falls; a read of any address returns 0x0000.
